// File: rtl/onn_phase_monitor.sv
`default_nettype none
// ============================================================================
// Module      : onn_phase_monitor
// Description : Phase-pattern monitor for an oscillatory neural network.
//               Neuron 0 is the phase reference. Over each observation
//               window the block counts, for every other neuron, the cycles
//               in which it disagrees with neuron 0. On a rising edge of
//               state_cheak each neuron is classified as in-phase or
//               anti-phase with the reference, and the phase pattern and
//               per-neuron change flags are updated. phi_to_no freezes the
//               result and raises result_valid. full_tick (re)loads a
//               starting pattern and restarts from any state.
// Revision    : 1.0 - initial release
//
// Ports
//   sclk          in   1   system clock
//   re_n          in   1   asynchronous active-low reset
//   full_tick     in   1   pattern-load / restart strobe
//   load_pattern  in  15   initial pattern loaded on full_tick
//   osc           in  15   neuron oscillator outputs (osc[0] = reference)
//   state_cheak   in   1   evaluate request (rising edge triggers)
//   phi_to_no     in   1   convergence / finish
//   state_changed out 15   per-neuron change flags of the last evaluation
//   pattern       out 15   current phase pattern
//   result_valid  out  1   final pattern valid
//   iter_cnt      out  8   evaluations performed (saturates at 255)
//   timeout       out  1   iteration limit reached (ONN_ITER_LIMIT_EN only)
//
// Build option
//   ONN_ITER_LIMIT_EN : when defined, an evaluation issued with iter_cnt
//                       already at 255 sets timeout and stops pattern updates.
// ============================================================================
module onn_phase_monitor (
   input  logic        sclk,
   input  logic        re_n,
   input  logic        full_tick,
   input  logic [14:0] load_pattern,
   input  logic [14:0] osc,
   input  logic        state_cheak,
   input  logic        phi_to_no,
   output logic [14:0] state_changed,
   output logic [14:0] pattern,
   output logic        result_valid,
   output logic [7:0]  iter_cnt
`ifdef ONN_ITER_LIMIT_EN
   ,
   output logic        timeout
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [7:0] C_SAT   = 8'hFF;

   logic [1:0]  state_q, state_d;
   logic [14:0] pattern_q, pattern_d;
   logic [14:0] chg_q, chg_d;
   logic [7:0]  iter_q, iter_d;
   logic [7:0]  win_q, win_d;
   logic [7:0]  mis_q [1:14];
   logic [7:0]  mis_d [1:14];
   logic        rv_q, rv_d;
   logic        chk_q;
`ifdef ONN_ITER_LIMIT_EN
   logic        to_q, to_d;
`endif

   logic        w_eval;
   logic        w_limit;
   logic [14:1] w_anti;
   logic [14:0] w_new;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == C_SAT) ? v : v + 8'd1;
   endfunction

   // Rising edge of state_cheak; the delayed copy resets to 0 so a level
   // already high when reset releases still counts as an edge.
   assign w_eval = state_cheak & ~chk_q;

`ifdef ONN_ITER_LIMIT_EN
   assign w_limit = (iter_q == C_SAT);
`else
   assign w_limit = 1'b0;
`endif

   // Anti-phase when the neuron disagreed with the reference in more than
   // half of the window: 2*mis > win, evaluated at 9 bits.
   genvar gi;
   generate
      for (gi = 1; gi < 15; gi++) begin : g_anti
         assign w_anti[gi] = {mis_q[gi], 1'b0} > {1'b0, win_q};
      end
   endgenerate

   // Neuron 0 keeps its phase; others follow it or its inverse.
   assign w_new = {w_anti ^ {14{pattern_q[0]}}, pattern_q[0]};

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      chg_d     = chg_q;
      iter_d    = iter_q;
      win_d     = win_q;
      mis_d     = mis_q;
      rv_d      = rv_q;
`ifdef ONN_ITER_LIMIT_EN
      to_d      = to_q;
`endif
      if (full_tick) begin
         state_d   = ST_ACC;
         pattern_d = load_pattern;
         chg_d     = '0;
         iter_d    = '0;
         win_d     = '0;
         for (int i = 1; i < 15; i++) mis_d[i] = '0;
         rv_d      = 1'b0;
`ifdef ONN_ITER_LIMIT_EN
         to_d      = 1'b0;
`endif
      end else begin
         case (state_q)
            ST_ACC: begin
               if (w_eval) begin
                  if (w_limit) begin
                     chg_d = '0;
`ifdef ONN_ITER_LIMIT_EN
                     to_d  = 1'b1;
`endif
                  end else if (win_q == 8'd0) begin
                     // Empty window carries no phase information.
                     chg_d = '0;
                  end else begin
                     chg_d     = w_new ^ pattern_q;
                     pattern_d = w_new;
                  end
                  iter_d = sat_inc(iter_q);
                  win_d  = '0;
                  for (int i = 1; i < 15; i++) mis_d[i] = '0;
               end else begin
                  win_d = sat_inc(win_q);
                  for (int i = 1; i < 15; i++) begin
                     if (osc[i] != osc[0]) mis_d[i] = sat_inc(mis_q[i]);
                  end
               end
               if (phi_to_no) begin
                  state_d = ST_DONE;
                  rv_d    = 1'b1;
               end
            end
            ST_IDLE, ST_DONE: begin
               state_d = state_q;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge sclk or negedge re_n) begin
      if (!re_n) begin
         state_q   <= ST_IDLE;
         pattern_q <= '0;
         chg_q     <= '0;
         iter_q    <= '0;
         win_q     <= '0;
         for (int i = 1; i < 15; i++) mis_q[i] <= '0;
         rv_q      <= 1'b0;
         chk_q     <= 1'b0;
`ifdef ONN_ITER_LIMIT_EN
         to_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         chg_q     <= chg_d;
         iter_q    <= iter_d;
         win_q     <= win_d;
         mis_q     <= mis_d;
         rv_q      <= rv_d;
         chk_q     <= state_cheak;
`ifdef ONN_ITER_LIMIT_EN
         to_q      <= to_d;
`endif
      end
   end

   assign state_changed = chg_q;
   assign pattern       = pattern_q;
   assign result_valid  = rv_q;
   assign iter_cnt      = iter_q;
`ifdef ONN_ITER_LIMIT_EN
   assign timeout       = to_q;
`endif

endmodule
`default_nettype wire
